uart_tx_sched: RTL

- Byte-transmit scheduler for the UART path.
- Accepts bytes from the game/control logic over a valid/ready handshake and buffers them in a small FIFO.
- Generates its own bit-period timing from the system clock and serialises each byte as a standard 8N1 frame on the tx line.
- Sits between the top-level control FSM and the board TX pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/uart_tx_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head word is visible on o_data.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  // Push is refused when full even if a pop happens on the same edge.
  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Buffered 8N1 UART transmitter with back-to-back framing.
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int          CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_cnt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt, w_head;
  logic                r_tx, w_tx_nxt, r_busy;
  logic                w_push, w_pop, w_cnt_clr, w_bit_done, w_has_data;
  logic [CW-1:0]       w_count_nxt;

  assign tx_ready    = (fifo_count < CW'(FIFO_DEPTH));
  assign w_push      = tx_valid && tx_ready;
  assign w_has_data  = (fifo_count != '0);
  assign w_bit_done  = (r_cnt == LAST);
  assign w_count_nxt = fifo_count + CW'(w_push) - CW'(w_pop);
  assign tx          = r_tx;
  assign busy        = r_busy;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (tx_data),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_count(fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_cnt_clr   = 1'b1;
        end
      end
      START: if (w_bit_done) begin
        w_state_nxt = DATA;
        w_idx_nxt   = 3'd0;
        w_tx_nxt    = r_shift[0];
      end
      DATA: if (w_bit_done) begin
        if (r_idx == 3'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = PARITY;
          w_tx_nxt    = ^r_shift;
`else
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
`endif
        end else begin
          w_idx_nxt = r_idx + 3'd1;
          w_tx_nxt  = r_shift[r_idx + 3'd1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_done) begin
        w_state_nxt = STOP;
        w_tx_nxt    = 1'b1;
      end
`endif
      STOP: if (w_bit_done) begin
        // Chain straight into the next start bit so frames have no idle gap.
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_idx   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_busy  <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr)                r_cnt <= '0;
    else if (r_state == IDLE || w_bit_done) r_cnt <= '0;
    else                                 r_cnt <= r_cnt + 16'd1;
  end

endmodule
